// File: rtl/univ_register.sv
// rtl/univ_register.sv - WIDTH-bit universal register: clear, load, shift, rotate, inc/dec
// A registered carry/borrow flag reports wrap-around of the most recent inc/dec.
module univ_register #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROTL = 3'b100,
    OP_ROTR = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_t;

  logic [WIDTH-1:0] next_data;
  logic             next_carry;

  always_comb begin
    next_data  = data_out;
    next_carry = 1'b0;
    case (op_t'(mode))
      OP_HOLD: next_data = data_out;
      OP_LOAD: next_data = data_in;
      OP_SHL:  next_data = {data_out[WIDTH-2:0], ser_in_r};
      OP_SHR:  next_data = {ser_in_l, data_out[WIDTH-1:1]};
      OP_ROTL: next_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      OP_ROTR: next_data = {data_out[0], data_out[WIDTH-1:1]};
      OP_INC: begin
        next_data  = data_out + 1'b1;
        next_carry = &data_out;
      end
      OP_DEC: begin
        next_data  = data_out - 1'b1;
        next_carry = ~|data_out;
      end
      default: next_data = data_out;
    endcase
  end

  // en=0 is the only path that retains carry; every enabled mode rewrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= RST_VAL;
      carry    <= 1'b0;
    end else if (clr) begin
      data_out <= RST_VAL;
      carry    <= 1'b0;
    end else if (en) begin
      data_out <= next_data;
      carry    <= next_carry;
    end
  end

  assign ser_out_l = data_out[WIDTH-1];
  assign ser_out_r = data_out[0];
  assign zero      = ~|data_out;

endmodule

// File: doc/univ_register.md
# univ_register

Parametrised universal register: a WIDTH-bit storage element with synchronous clear, parallel load, logical shift, rotate and wrap-around increment/decrement. A registered carry/borrow flag accompanies the arithmetic modes. It supersedes the plain load-every-cycle register as the general-purpose state element for datapaths, serialisers and small counters.

## Interface
- WIDTH, 8, data width in bits; legal range is 2 or more.
- RST_VAL, 0, value loaded into data_out by reset and by clr; WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to RST_VAL; overrides en and mode.
- en  input  1  operation enable; when low the register holds.
- mode  input  3  operation select (see Operation).
- data_in  input  WIDTH  parallel load value.
- ser_in_l  input  1  serial fill bit entering at the MSB on shift-right.
- ser_in_r  input  1  serial fill bit entering at the LSB on shift-left.
- data_out  output  WIDTH  register contents.
- ser_out_l  output  1  equals data_out[WIDTH-1].
- ser_out_r  output  1  equals data_out[0].
- carry  output  1  registered wrap flag from the most recent inc/dec.
- zero  output  1  high when data_out is all zeros.

## Operation
Priority per rising edge is rst, then clr, then en. The mode encoding applies when en=1:
- 000 HOLD: data_out is unchanged.
- 001 LOAD: data_out <= data_in.
- 010 SHL: data_out <= {data_out[WIDTH-2:0], ser_in_r}.
- 011 SHR: data_out <= {ser_in_l, data_out[WIDTH-1:1]}.
- 100 ROTL: data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}.
- 101 ROTR: data_out <= {data_out[0], data_out[WIDTH-1:1]}.
- 110 INC: data_out <= data_out + 1, modulo 2^WIDTH. carry <= 1 only when the old value was all ones.
- 111 DEC: data_out <= data_out - 1, modulo 2^WIDTH. carry <= 1 only when the old value was all zeros (borrow).

Carry rules:
- carry updates only on INC or DEC with en=1.
- Every other mode with en=1 clears carry to 0.
- HOLD via en=0 keeps carry.
- clr and rst force carry to 0.

Other rules:
- The ser_in_* inputs are ignored outside SHL/SHR.
- data_in is ignored outside LOAD.
- ser_out_l, ser_out_r and zero are combinational decodes of data_out only. There is no input-to-output combinational path.

## Timing
- Reset: asserting rst immediately drives data_out=RST_VAL and carry=0, with no clock required. The derived outputs follow: zero=(RST_VAL==0), ser_out_l=RST_VAL[WIDTH-1], ser_out_r=RST_VAL[0].
- Release of rst is synchronous in effect: the first rising edge with rst=0 performs the selected operation.
- Reset mid-operation: any pending shift, count or load is discarded. There is no residual state.
- Latency: inputs sampled on rising edge N appear on data_out after edge N. This gives one cycle of latency and a throughput of one operation per cycle.
- Back-to-back operations of differing modes on consecutive edges are legal and independent.
- clr together with en=1 and any mode yields RST_VAL, carry=0.
- Simultaneous events have no hazard: a single register stage updates atomically.
- Wrap-around: INC from all-ones gives 0 with carry=1. DEC from 0 gives all-ones with carry=1. Neither mode saturates.

## Test plan
All scenarios use WIDTH=8, RST_VAL=8'h00 unless stated.
- Reset: assert rst mid-cycle with data_out=8'h3C -> data_out=8'h00, carry=0, zero=1 before the next edge. Then release, LOAD 8'h55 -> 8'h55 after one edge.
- Load/hold: LOAD 8'hAA, then en=0 with data_in=8'hFF for 3 cycles -> data_out stays 8'hAA. Then clr=1 with en=1, mode=LOAD -> 8'h00.
- Shift/rotate: from 8'h81, do SHL with ser_in_r=0 -> 8'h02. Then SHR with ser_in_l=1 -> 8'h81. Then ROTL -> 8'h03. Then ROTR twice -> 8'hC0. Check ser_out_l and ser_out_r each cycle.
- Counter wrap: LOAD 8'hFE, then INC -> 8'hFF with carry=0. INC -> 8'h00 with carry=1, zero=1. DEC -> 8'hFF with carry=1. DEC -> 8'hFE with carry=0.
- Carry retention: after carry=1 from wrap, en=0 for 2 cycles -> carry stays 1. Next SHL -> carry=0.
- Parameter check: WIDTH=16, RST_VAL=16'hA5A5. Reset -> data_out=16'hA5A5. clr -> 16'hA5A5. INC from 16'hFFFF -> 16'h0000 with carry=1.
